uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16'd50000: maximum idle PCLK cycles between bytes within a frame.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 SHALL have port PCLK  in  1  system clock; all logic on rising edge.
REQ-005 SHALL have port PRESETN  in  1  synchronous active-low reset.
REQ-006 SHALL have port RX_DATA  in  8  received UART byte, valid only when RX_VALID=1.
REQ-007 SHALL have port RX_VALID  in  1  single-cycle strobe, one per received byte.
REQ-008 SHALL have port PARITY_ERR  in  1  parity error for the current byte, sampled only with RX_VALID.
REQ-009 SHALL have port FRAMING_ERR  in  1  framing error for the current byte, sampled only with RX_VALID.
REQ-010 SHALL have port CMD_VALID  out  1  decoded command available.
REQ-011 SHALL have port CMD_READY  in  1  consumer accepts command.
REQ-012 SHALL have port CMD_OP  out  8  command opcode.
REQ-013 SHALL have port CMD_ARG  out  16  command argument {ARG_HI, ARG_LO}.
REQ-014 SHALL have port BUSY  out  1  high in any state other than IDLE.
REQ-015 SHALL have port CSUM_ERR_CNT  out  8  saturating count of checksum failures.
REQ-016 SHALL have port LINE_ERR_CNT  out  8  saturating count of parity/framing-aborted frames.
REQ-017 SHALL have port TIMEOUT_CNT  out  8  saturating count of inter-byte timeouts.
REQ-018 SHALL have port OVERRUN_CNT  out  8  saturating count of bytes dropped while in HOLD.

Function
REQ-019 SHALL parse the frame SYNC_BYTE, OP, ARG_HI, ARG_LO, CSUM, where CSUM = OP ^ ARG_HI ^ ARG_LO.
REQ-020 SHALL implement states IDLE, OP, ARG_HI, ARG_LO, CSUM, HOLD, where each state names the next byte expected.
REQ-021 SHALL, in IDLE on RX_VALID with RX_DATA==SYNC_BYTE and no error, go to OP; any other byte is silently ignored with no counter change.
REQ-022 SHALL, in OP/ARG_HI/ARG_LO on a valid byte, latch it into a shadow register and advance one state.
REQ-023 SHALL, in CSUM with matching checksum, load CMD_OP/CMD_ARG from the shadows, assert CMD_VALID on the next cycle and go to HOLD (latency: 1 cycle after the CSUM strobe).
REQ-024 SHALL, in CSUM with a mismatching checksum, go to IDLE and increment CSUM_ERR_CNT; CMD_VALID stays low.
REQ-025 SHALL treat SYNC_BYTE received mid-frame as ordinary data; there is no resynchronisation.
REQ-026 SHALL, on RX_VALID with PARITY_ERR|FRAMING_ERR in any state except IDLE and HOLD, abort to IDLE and increment LINE_ERR_CNT; an errored byte in IDLE is ignored.
REQ-027 SHALL, in HOLD, hold CMD_VALID, CMD_OP and CMD_ARG stable until CMD_VALID&CMD_READY, then drop CMD_VALID and go to IDLE on the next edge.
REQ-028 SHALL, in HOLD, drop any RX_VALID byte and increment OVERRUN_CNT, unless CMD_READY=1 in the same cycle, in which case the byte is evaluated with IDLE rules (a SYNC goes directly to OP).
REQ-029 SHALL run a 16-bit inter-byte timer in OP..CSUM that clears on each RX_VALID and on entering OP, and counts otherwise.
REQ-030 SHALL, when the timer reaches TIMEOUT_CYCLES-1 without RX_VALID, go to IDLE and increment TIMEOUT_CNT; if RX_VALID arrives in the same cycle, the byte wins and no timeout occurs.
REQ-031 SHALL keep the timer inactive in IDLE and HOLD.
REQ-032 SHALL saturate all counters at 8'hFF with no wrap; one event increments at most one counter per cycle.

Reset
REQ-033 SHALL, on PRESETN=0 at a rising PCLK edge, set state IDLE, CMD_VALID=0, CMD_OP=8'h00, CMD_ARG=16'h0000, BUSY=0, the timer and all counters 0, regardless of state, including a frame or HOLD in progress.
REQ-034 SHALL ignore inputs during reset; the first byte considered is the one strobed on the first edge with PRESETN=1.

Verification
REQ-035 SHALL be verified with bytes A5,12,34,56,70 and CMD_READY=1 -> CMD_VALID for exactly 1 cycle, CMD_OP=8'h12, CMD_ARG=16'h3456.
REQ-036 SHALL be verified with bytes A5,12,34,56,71 -> no CMD_VALID, CSUM_ERR_CNT=1, BUSY=0.
REQ-037 SHALL be verified with TIMEOUT_CYCLES=16, bytes A5,12 then 20 idle cycles -> TIMEOUT_CNT=1, state IDLE; then a full good frame decodes correctly.
REQ-038 SHALL be verified with CMD_READY=0 after a good frame, then 3 bytes plus a fresh frame -> OVERRUN_CNT increments per dropped byte, CMD outputs unchanged; CMD_READY=1 together with A5 -> the next frame decodes.
REQ-039 SHALL be verified with FRAMING_ERR on the ARG_LO byte -> LINE_ERR_CNT=1, no command; and with 300 bad-checksum frames -> CSUM_ERR_CNT=8'hFF.
REQ-040 SHALL be verified with PRESETN=0 asserted while in HOLD -> CMD_VALID=0, all outputs at reset values on the next edge.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// UART command frame parser: SYNC, OP, ARG_HI, ARG_LO, CSUM (CSUM = OP ^ ARG_HI ^ ARG_LO).
// Decoded commands are presented on a valid/ready handshake; line, checksum, timeout and overrun events are counted.
module uart_cmd_parser #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    input  logic        PARITY_ERR,
    input  logic        FRAMING_ERR,
    output logic        CMD_VALID,
    input  logic        CMD_READY,
    output logic [7:0]  CMD_OP,
    output logic [15:0] CMD_ARG,
    output logic        BUSY,
    output logic [7:0]  CSUM_ERR_CNT,
    output logic [7:0]  LINE_ERR_CNT,
    output logic [7:0]  TIMEOUT_CNT,
    output logic [7:0]  OVERRUN_CNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP,
        S_ARG_HI,
        S_ARG_LO,
        S_CSUM,
        S_HOLD
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  op_sh;
    logic [7:0]  hi_sh;
    logic [7:0]  lo_sh;
    logic [15:0] timer;

    logic line_err;
    logic is_sync;
    logic csum_ok;
    logic timer_expired;
    logic in_frame;

    logic load_op;
    logic load_hi;
    logic load_lo;
    logic load_cmd;
    logic inc_csum;
    logic inc_line;
    logic inc_timeout;
    logic inc_overrun;

    assign line_err      = PARITY_ERR | FRAMING_ERR;
    assign is_sync       = RX_VALID && !line_err && (RX_DATA == SYNC_BYTE);
    assign csum_ok       = ((op_sh ^ hi_sh ^ lo_sh) == RX_DATA);
    assign timer_expired = (timer == (TIMEOUT_CYCLES - 16'd1));
    assign in_frame      = (state == S_OP) || (state == S_ARG_HI) ||
                           (state == S_ARG_LO) || (state == S_CSUM);
    assign BUSY          = (state != S_IDLE);

    always_comb begin
        state_next  = state;
        load_op     = 1'b0;
        load_hi     = 1'b0;
        load_lo     = 1'b0;
        load_cmd    = 1'b0;
        inc_csum    = 1'b0;
        inc_line    = 1'b0;
        inc_timeout = 1'b0;
        inc_overrun = 1'b0;

        case (state)
            S_IDLE: begin
                if (is_sync) begin
                    state_next = S_OP;
                end
            end
            S_OP, S_ARG_HI, S_ARG_LO, S_CSUM: begin
                // A byte arriving on the expiry cycle takes priority over the timeout.
                if (RX_VALID) begin
                    if (line_err) begin
                        state_next = S_IDLE;
                        inc_line   = 1'b1;
                    end else begin
                        case (state)
                            S_OP: begin
                                load_op    = 1'b1;
                                state_next = S_ARG_HI;
                            end
                            S_ARG_HI: begin
                                load_hi    = 1'b1;
                                state_next = S_ARG_LO;
                            end
                            S_ARG_LO: begin
                                load_lo    = 1'b1;
                                state_next = S_CSUM;
                            end
                            default: begin
                                if (csum_ok) begin
                                    load_cmd   = 1'b1;
                                    state_next = S_HOLD;
                                end else begin
                                    inc_csum   = 1'b1;
                                    state_next = S_IDLE;
                                end
                            end
                        endcase
                    end
                end else if (timer_expired) begin
                    state_next  = S_IDLE;
                    inc_timeout = 1'b1;
                end
            end
            S_HOLD: begin
                // Accepting the command frees the parser, so a same-cycle byte gets idle treatment.
                if (CMD_READY) begin
                    state_next = is_sync ? S_OP : S_IDLE;
                end else if (RX_VALID) begin
                    inc_overrun = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            op_sh     <= 8'h00;
            hi_sh     <= 8'h00;
            lo_sh     <= 8'h00;
            CMD_OP    <= 8'h00;
            CMD_ARG   <= 16'h0000;
            CMD_VALID <= 1'b0;
            timer     <= 16'h0000;
        end else begin
            if (load_op) begin
                op_sh <= RX_DATA;
            end
            if (load_hi) begin
                hi_sh <= RX_DATA;
            end
            if (load_lo) begin
                lo_sh <= RX_DATA;
            end
            if (load_cmd) begin
                CMD_OP  <= op_sh;
                CMD_ARG <= {hi_sh, lo_sh};
            end
            CMD_VALID <= (state_next == S_HOLD);
            if (in_frame && !RX_VALID && !timer_expired) begin
                timer <= timer + 16'd1;
            end else begin
                timer <= 16'h0000;
            end
        end
    end

    // Event counters stick at 8'hFF instead of wrapping.
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            CSUM_ERR_CNT <= 8'h00;
            LINE_ERR_CNT <= 8'h00;
            TIMEOUT_CNT  <= 8'h00;
            OVERRUN_CNT  <= 8'h00;
        end else begin
            if (inc_csum && (CSUM_ERR_CNT != 8'hFF)) begin
                CSUM_ERR_CNT <= CSUM_ERR_CNT + 8'd1;
            end
            if (inc_line && (LINE_ERR_CNT != 8'hFF)) begin
                LINE_ERR_CNT <= LINE_ERR_CNT + 8'd1;
            end
            if (inc_timeout && (TIMEOUT_CNT != 8'hFF)) begin
                TIMEOUT_CNT <= TIMEOUT_CNT + 8'd1;
            end
            if (inc_overrun && (OVERRUN_CNT != 8'hFF)) begin
                OVERRUN_CNT <= OVERRUN_CNT + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: a byte-queue frame model compared every cycle,
// plus literal checkpoints for the directed scenarios.
module tb_uart_cmd_parser;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         TOUT = 16;

    logic        PCLK;
    logic        PRESETN;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        PARITY_ERR;
    logic        FRAMING_ERR;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [7:0]  CMD_OP;
    logic [15:0] CMD_ARG;
    logic        BUSY;
    logic [7:0]  CSUM_ERR_CNT;
    logic [7:0]  LINE_ERR_CNT;
    logic [7:0]  TIMEOUT_CNT;
    logic [7:0]  OVERRUN_CNT;

    int checks   = 0;
    int failures = 0;
    int hs_cnt   = 0;
    int hs_start;

    uart_cmd_parser #(
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (16'd16)
    ) dut (
        .PCLK         (PCLK),
        .PRESETN      (PRESETN),
        .RX_DATA      (RX_DATA),
        .RX_VALID     (RX_VALID),
        .PARITY_ERR   (PARITY_ERR),
        .FRAMING_ERR  (FRAMING_ERR),
        .CMD_VALID    (CMD_VALID),
        .CMD_READY    (CMD_READY),
        .CMD_OP       (CMD_OP),
        .CMD_ARG      (CMD_ARG),
        .BUSY         (BUSY),
        .CSUM_ERR_CNT (CSUM_ERR_CNT),
        .LINE_ERR_CNT (LINE_ERR_CNT),
        .TIMEOUT_CNT  (TIMEOUT_CNT),
        .OVERRUN_CNT  (OVERRUN_CNT)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Frame model: bytes collected so far, idle gap length, pending command and counters.
    logic [7:0]  m_frame[$];
    int          m_gap   = 0;
    logic        m_hold  = 1'b0;
    logic        m_valid = 1'b0;
    logic [7:0]  m_op    = 8'h00;
    logic [15:0] m_arg   = 16'h0000;
    logic [7:0]  m_csum  = 8'h00;
    logic [7:0]  m_line  = 8'h00;
    logic [7:0]  m_to    = 8'h00;
    logic [7:0]  m_ovr   = 8'h00;
    logic        m_live  = 1'b0;

    function automatic logic [7:0] sat(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always @(posedge PCLK) begin
        logic good;
        good = RX_VALID && !PARITY_ERR && !FRAMING_ERR;
        if (!PRESETN) begin
            m_frame.delete();
            m_gap   = 0;
            m_hold  = 1'b0;
            m_valid = 1'b0;
            m_op    = 8'h00;
            m_arg   = 16'h0000;
            m_csum  = 8'h00;
            m_line  = 8'h00;
            m_to    = 8'h00;
            m_ovr   = 8'h00;
            m_live  = 1'b1;
        end else if (m_hold) begin
            if (CMD_READY) begin
                m_hold  = 1'b0;
                m_valid = 1'b0;
                if (good && RX_DATA == SYNC) begin
                    m_frame.push_back(RX_DATA);
                    m_gap = 0;
                end
            end else if (RX_VALID) begin
                m_ovr = sat(m_ovr);
            end
        end else if (m_frame.size() == 0) begin
            if (good && RX_DATA == SYNC) begin
                m_frame.push_back(RX_DATA);
                m_gap = 0;
            end
        end else if (RX_VALID) begin
            if (!good) begin
                m_frame.delete();
                m_line = sat(m_line);
            end else if (m_frame.size() == 4) begin
                if ((m_frame[1] ^ m_frame[2] ^ m_frame[3]) == RX_DATA) begin
                    m_op    = m_frame[1];
                    m_arg   = {m_frame[2], m_frame[3]};
                    m_valid = 1'b1;
                    m_hold  = 1'b1;
                end else begin
                    m_csum = sat(m_csum);
                end
                m_frame.delete();
            end else begin
                m_frame.push_back(RX_DATA);
                m_gap = 0;
            end
        end else if (m_gap == TOUT - 1) begin
            m_frame.delete();
            m_to = sat(m_to);
        end else begin
            m_gap++;
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge PCLK) begin
        if (m_live) begin
            checkOutput("cmp_valid", {15'd0, CMD_VALID}, {15'd0, m_valid});
            checkOutput("cmp_op", {8'd0, CMD_OP}, {8'd0, m_op});
            checkOutput("cmp_arg", CMD_ARG, m_arg);
            checkOutput("cmp_busy", {15'd0, BUSY}, {15'd0, (m_hold || m_frame.size() != 0)});
            checkOutput("cmp_csum_cnt", {8'd0, CSUM_ERR_CNT}, {8'd0, m_csum});
            checkOutput("cmp_line_cnt", {8'd0, LINE_ERR_CNT}, {8'd0, m_line});
            checkOutput("cmp_to_cnt", {8'd0, TIMEOUT_CNT}, {8'd0, m_to});
            checkOutput("cmp_ovr_cnt", {8'd0, OVERRUN_CNT}, {8'd0, m_ovr});
        end
        if (CMD_VALID === 1'b1 && CMD_READY === 1'b1) begin
            hs_cnt++;
        end
    end

    // Entered and left one time unit after a rising edge; drives one byte strobe for one cycle.
    task automatic applyStimulus(input logic [7:0] d, input logic pe, input logic fe);
        RX_VALID    = 1'b1;
        RX_DATA     = d;
        PARITY_ERR  = pe;
        FRAMING_ERR = fe;
        @(posedge PCLK);
        #1;
        RX_VALID    = 1'b0;
        PARITY_ERR  = 1'b0;
        FRAMING_ERR = 1'b0;
    endtask

    task automatic sendFrame(input logic [7:0] op, input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] cs);
        applyStimulus(SYNC, 1'b0, 1'b0);
        applyStimulus(op, 1'b0, 1'b0);
        applyStimulus(hi, 1'b0, 1'b0);
        applyStimulus(lo, 1'b0, 1'b0);
        applyStimulus(cs, 1'b0, 1'b0);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        PRESETN     = 1'b0;
        RX_DATA     = 8'h00;
        RX_VALID    = 1'b0;
        PARITY_ERR  = 1'b0;
        FRAMING_ERR = 1'b0;
        CMD_READY   = 1'b0;
        // Bytes strobed during reset must be ignored.
        @(posedge PCLK);
        #1;
        RX_VALID = 1'b1;
        RX_DATA  = SYNC;
        idleCycles(2);
        RX_VALID = 1'b0;
        PRESETN  = 1'b1;

        checkOutput("rst_valid", {15'd0, CMD_VALID}, 16'h0000);
        checkOutput("rst_op", {8'd0, CMD_OP}, 16'h0000);
        checkOutput("rst_arg", CMD_ARG, 16'h0000);
        checkOutput("rst_busy", {15'd0, BUSY}, 16'h0000);
        checkOutput("rst_csum_cnt", {8'd0, CSUM_ERR_CNT}, 16'h0000);
        checkOutput("rst_ovr_cnt", {8'd0, OVERRUN_CNT}, 16'h0000);

        // Good frame with the consumer always ready: one-cycle pulse.
        CMD_READY = 1'b1;
        hs_start  = hs_cnt;
        sendFrame(8'h12, 8'h34, 8'h56, 8'h70);
        checkOutput("good_valid", {15'd0, CMD_VALID}, 16'h0001);
        checkOutput("good_op", {8'd0, CMD_OP}, 16'h0012);
        checkOutput("good_arg", CMD_ARG, 16'h3456);
        idleCycles(2);
        checkOutput("good_valid_drop", {15'd0, CMD_VALID}, 16'h0000);
        checkOutput("good_pulse_count", 16'(hs_cnt - hs_start), 16'h0001);

        // Bad checksum.
        sendFrame(8'h12, 8'h34, 8'h56, 8'h71);
        checkOutput("bad_csum_valid", {15'd0, CMD_VALID}, 16'h0000);
        checkOutput("bad_csum_cnt", {8'd0, CSUM_ERR_CNT}, 16'h0001);
        checkOutput("bad_csum_busy", {15'd0, BUSY}, 16'h0000);

        // Inter-byte timeout, then recovery.
        applyStimulus(SYNC, 1'b0, 1'b0);
        applyStimulus(8'h12, 1'b0, 1'b0);
        idleCycles(20);
        checkOutput("to_cnt", {8'd0, TIMEOUT_CNT}, 16'h0001);
        checkOutput("to_busy", {15'd0, BUSY}, 16'h0000);
        sendFrame(8'h01, 8'h02, 8'h03, 8'h00);
        checkOutput("to_recover_valid", {15'd0, CMD_VALID}, 16'h0001);
        checkOutput("to_recover_op", {8'd0, CMD_OP}, 16'h0001);
        checkOutput("to_recover_arg", CMD_ARG, 16'h0203);
        idleCycles(1);

        // A byte on the final cycle before expiry wins over the timeout.
        applyStimulus(SYNC, 1'b0, 1'b0);
        idleCycles(TOUT - 1);
        applyStimulus(8'h12, 1'b0, 1'b0);
        applyStimulus(8'h34, 1'b0, 1'b0);
        applyStimulus(8'h56, 1'b0, 1'b0);
        applyStimulus(8'h70, 1'b0, 1'b0);
        checkOutput("edge_to_cnt", {8'd0, TIMEOUT_CNT}, 16'h0001);
        checkOutput("edge_valid", {15'd0, CMD_VALID}, 16'h0001);
        idleCycles(1);

        // Mid-frame SYNC bytes are plain data.
        sendFrame(SYNC, SYNC, SYNC, SYNC);
        checkOutput("sync_data_op", {8'd0, CMD_OP}, 16'h00A5);
        checkOutput("sync_data_arg", CMD_ARG, 16'hA5A5);
        idleCycles(1);

        // Overrun while holding a command.
        CMD_READY = 1'b0;
        sendFrame(8'hAB, 8'hCD, 8'hEF, 8'h89);
        applyStimulus(8'h11, 1'b0, 1'b0);
        applyStimulus(8'h22, 1'b0, 1'b0);
        applyStimulus(8'h33, 1'b0, 1'b0);
        sendFrame(8'h10, 8'h20, 8'h30, 8'h00);
        idleCycles(30);
        checkOutput("hold_valid", {15'd0, CMD_VALID}, 16'h0001);
        checkOutput("hold_op", {8'd0, CMD_OP}, 16'h00AB);
        checkOutput("hold_arg", CMD_ARG, 16'hCDEF);
        checkOutput("hold_ovr_cnt", {8'd0, OVERRUN_CNT}, 16'h0008);
        checkOutput("hold_to_cnt", {8'd0, TIMEOUT_CNT}, 16'h0001);
        CMD_READY = 1'b1;
        applyStimulus(SYNC, 1'b0, 1'b0);
        checkOutput("hs_sync_valid", {15'd0, CMD_VALID}, 16'h0000);
        checkOutput("hs_sync_busy", {15'd0, BUSY}, 16'h0001);
        applyStimulus(8'h10, 1'b0, 1'b0);
        applyStimulus(8'h20, 1'b0, 1'b0);
        applyStimulus(8'h30, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("hs_next_op", {8'd0, CMD_OP}, 16'h0010);
        checkOutput("hs_next_arg", CMD_ARG, 16'h2030);
        checkOutput("hs_next_ovr_cnt", {8'd0, OVERRUN_CNT}, 16'h0008);
        idleCycles(1);

        // Line errors: ignored in IDLE, abort mid-frame.
        applyStimulus(SYNC, 1'b1, 1'b0);
        checkOutput("idle_err_busy", {15'd0, BUSY}, 16'h0000);
        applyStimulus(SYNC, 1'b0, 1'b0);
        applyStimulus(8'h12, 1'b0, 1'b0);
        applyStimulus(8'h34, 1'b0, 1'b0);
        applyStimulus(8'h56, 1'b0, 1'b1);
        checkOutput("ferr_line_cnt", {8'd0, LINE_ERR_CNT}, 16'h0001);
        checkOutput("ferr_busy", {15'd0, BUSY}, 16'h0000);
        applyStimulus(SYNC, 1'b0, 1'b0);
        applyStimulus(8'h12, 1'b1, 1'b0);
        checkOutput("perr_line_cnt", {8'd0, LINE_ERR_CNT}, 16'h0002);

        // Checksum counter saturation.
        for (int i = 0; i < 300; i++) begin
            sendFrame(8'h00, 8'h00, 8'h00, 8'h01);
        end
        checkOutput("csum_sat", {8'd0, CSUM_ERR_CNT}, 16'h00FF);

        // Reset while holding a command.
        CMD_READY = 1'b0;
        sendFrame(8'h12, 8'h34, 8'h56, 8'h70);
        checkOutput("pre_rst_valid", {15'd0, CMD_VALID}, 16'h0001);
        PRESETN = 1'b0;
        idleCycles(1);
        checkOutput("hold_rst_valid", {15'd0, CMD_VALID}, 16'h0000);
        checkOutput("hold_rst_op", {8'd0, CMD_OP}, 16'h0000);
        checkOutput("hold_rst_arg", CMD_ARG, 16'h0000);
        checkOutput("hold_rst_busy", {15'd0, BUSY}, 16'h0000);
        checkOutput("hold_rst_csum_cnt", {8'd0, CSUM_ERR_CNT}, 16'h0000);
        checkOutput("hold_rst_line_cnt", {8'd0, LINE_ERR_CNT}, 16'h0000);
        PRESETN   = 1'b1;
        CMD_READY = 1'b1;
        sendFrame(8'h12, 8'h34, 8'h56, 8'h70);
        checkOutput("post_rst_op", {8'd0, CMD_OP}, 16'h0012);
        idleCycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
